// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the Memoria port arbiter.
// Optional round-robin tie-break is enabled with MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_DBG = 1'b1;

   localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU and debug requesters.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the requester that did not own the last access.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic cpu_req,
   input  logic dbg_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  logic last_owner,
`endif
   output logic any_req,
   output logic win_owner
);

   always_comb begin
      any_req   = cpu_req | dbg_req;
      win_owner = OWNER_CPU;
      if (cpu_req && dbg_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         win_owner = ~last_owner;
`else
         win_owner = OWNER_CPU;
`endif
      end else if (dbg_req) begin
         win_owner = OWNER_DBG;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences single-port Memoria accesses for the CPU and debug/loader ports.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking instead of fixed CPU priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_wr,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
      $error("mem_port_arbiter: RD_LAT must be in 1..15");
   end

   arb_state_t        state;
   arb_state_t        state_nxt;

   logic              lat_wr;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              lat_owner;
   logic [CNT_W-1:0]  rd_cnt;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dbg_rdata_q;

   logic              pick_any;
   logic              pick_owner;
   logic              rd_last;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic              last_owner;
`endif

   mem_arb_pick u_pick (
      .cpu_req    (cpu_req),
      .dbg_req    (dbg_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
      .last_owner (last_owner),
`endif
      .any_req    (pick_any),
      .win_owner  (pick_owner)
   );

   assign rd_last = (rd_cnt == CNT_W'(1));

   always_ff @(posedge Clk) begin
      if (reset) begin
         state       <= IDLE;
         lat_wr      <= 1'b0;
         lat_addr    <= '0;
         lat_wdata   <= '0;
         lat_owner   <= OWNER_CPU;
         rd_cnt      <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  lat_owner <= pick_owner;
                  if (pick_owner == OWNER_DBG) begin
                     lat_wr    <= dbg_wr;
                     lat_addr  <= dbg_addr;
                     lat_wdata <= dbg_wdata;
                  end else begin
                     lat_wr    <= cpu_wr;
                     lat_addr  <= cpu_addr;
                     lat_wdata <= cpu_wdata;
                  end
               end
            end
            ISSUE: begin
               if (!lat_wr) begin
                  rd_cnt <= CNT_W'(RD_LAT);
               end
            end
            WAIT: begin
               rd_cnt <= rd_cnt - CNT_W'(1);
               if (rd_last) begin
                  if (lat_owner == OWNER_DBG) begin
                     dbg_rdata_q <= mem_rdata;
                  end else begin
                     cpu_rdata_q <= mem_rdata;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Starting from DBG lets the CPU take the first tie after reset.
   always_ff @(posedge Clk) begin
      if (reset) begin
         last_owner <= OWNER_DBG;
      end else if (state == ISSUE) begin
         last_owner <= lat_owner;
      end
   end
`endif

   always_comb begin
      state_nxt  = state;
      cpu_gnt    = 1'b0;
      dbg_gnt    = 1'b0;
      cpu_rvalid = 1'b0;
      dbg_rvalid = 1'b0;
      mem_wr     = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            mem_wr    = lat_wr;
            cpu_gnt   = (lat_owner == OWNER_CPU);
            dbg_gnt   = (lat_owner == OWNER_DBG);
            state_nxt = lat_wr ? IDLE : WAIT;
         end
         WAIT: begin
            if (rd_last) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            cpu_rvalid = (lat_owner == OWNER_CPU);
            dbg_rvalid = (lat_owner == OWNER_DBG);
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The latch only changes when leaving IDLE, so the memory bus holds between accesses.
   assign mem_addr   = lat_addr;
   assign mem_wdata  = lat_wdata;
   assign busy       = (state != IDLE);
   assign owner      = lat_owner;
   assign cpu_rdata  = cpu_rdata_q;
   assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses, grant/rvalid events checked by a monitor.
module tb_mem_port_arbiter;

   localparam int EV_CPU_GNT = 0;
   localparam int EV_DBG_GNT = 1;
   localparam int EV_CPU_RV  = 2;
   localparam int EV_DBG_RV  = 3;

   logic        Clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_wr, dbg_req, dbg_wr;
   logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
   logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [31:0] cpu_rdata, dbg_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_wr, busy, owner;

   logic        c1_cpu_req, c1_cpu_wr, c1_dbg_req, c1_dbg_wr;
   logic [31:0] c1_cpu_addr, c1_cpu_wdata, c1_dbg_addr, c1_dbg_wdata;
   logic        c1_cpu_gnt, c1_cpu_rvalid, c1_dbg_gnt, c1_dbg_rvalid;
   logic [31:0] c1_cpu_rdata, c1_dbg_rdata;
   logic [31:0] c1_mem_addr, c1_mem_wdata, c1_mem_rdata;
   logic        c1_mem_wr, c1_busy, c1_owner;

   logic [31:0] mem [0:255];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      int          kind;
      int          cyc;
      logic [31:0] val;
   } exp_t;
   exp_t q[$];

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   assign mem_rdata    = mem[mem_addr[7:0]];
   assign c1_mem_rdata = mem[c1_mem_addr[7:0]];
   always @(posedge Clk) if (mem_wr === 1'b1) mem[mem_addr[7:0]] <= mem_wdata;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2)) u_dut (
      .Clk(Clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut_lat1 (
      .Clk(Clk), .reset(reset),
      .cpu_req(c1_cpu_req), .cpu_wr(c1_cpu_wr), .cpu_addr(c1_cpu_addr), .cpu_wdata(c1_cpu_wdata),
      .cpu_gnt(c1_cpu_gnt), .cpu_rvalid(c1_cpu_rvalid), .cpu_rdata(c1_cpu_rdata),
      .dbg_req(c1_dbg_req), .dbg_wr(c1_dbg_wr), .dbg_addr(c1_dbg_addr), .dbg_wdata(c1_dbg_wdata),
      .dbg_gnt(c1_dbg_gnt), .dbg_rvalid(c1_dbg_rvalid), .dbg_rdata(c1_dbg_rdata),
      .mem_addr(c1_mem_addr), .mem_wr(c1_mem_wr), .mem_wdata(c1_mem_wdata), .mem_rdata(c1_mem_rdata),
      .busy(c1_busy), .owner(c1_owner)
   );

   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_ev(input int kind, input int c, input logic [31:0] v);
      exp_t e;
      e.kind = kind;
      e.cyc  = c;
      e.val  = v;
      q.push_back(e);
   endtask

   // Monitor: every gnt/rvalid pulse must match the oldest outstanding expectation.
   initial begin
      forever begin
         @(negedge Clk);
         for (int k = 0; k < 4; k++) begin
            logic        hit;
            logic [31:0] v;
            exp_t        e;
            case (k)
               EV_CPU_GNT: begin hit = cpu_gnt;    v = mem_addr;  end
               EV_DBG_GNT: begin hit = dbg_gnt;    v = mem_addr;  end
               EV_CPU_RV:  begin hit = cpu_rvalid; v = cpu_rdata; end
               default:    begin hit = dbg_rvalid; v = dbg_rdata; end
            endcase
            if (hit === 1'b1) begin
               total++;
               if (q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_event: got kind=%0d cycle=%0d val=%h want none", k, cyc, v);
               end else begin
                  e = q.pop_front();
                  if (k != e.kind || cyc != e.cyc || v !== e.val) begin
                     bad++;
                     $display("FAIL event: got kind=%0d cycle=%0d val=%h want kind=%0d cycle=%0d val=%h",
                              k, cyc, v, e.kind, e.cyc, e.val);
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      reset = 1'b1;
      cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_wr = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      c1_cpu_req = 1'b0; c1_cpu_wr = 1'b0; c1_cpu_addr = '0; c1_cpu_wdata = '0;
      c1_dbg_req = 1'b0; c1_dbg_wr = 1'b0; c1_dbg_addr = '0; c1_dbg_wdata = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h40] = 32'hDEADBEEF;
      mem[8'h20] = 32'hA5A50001;
      mem[8'h24] = 32'h5A5A0002;

      step(3);
      reset = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_pulses", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_wr, owner}, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
      step(1);

      // CPU read of 0x40
      c0 = cyc;
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h40;
      expect_ev(EV_CPU_GNT, c0 + 1, 32'h40);
      expect_ev(EV_CPU_RV,  c0 + 4, 32'hDEADBEEF);
      step(1);
      cpu_req = 1'b0; cpu_addr = 32'hFFFF_FFFF;
      check("rd_c1_addr", mem_addr, 32'h40);
      check("rd_c1_wr", mem_wr, 0);
      step(1);
      check("rd_c2_addr_wr_busy", {mem_addr, mem_wr, busy}, {32'h40, 1'b0, 1'b1});
      step(1);
      check("rd_c3_addr", mem_addr, 32'h40);
      step(2);
      check("rd_c5_busy", busy, 0);

      // DBG write 0x10 <= 0x12345678, then read it back
      c0 = cyc;
      dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'h12345678;
      expect_ev(EV_DBG_GNT, c0 + 1, 32'h10);
      step(1);
      dbg_req = 1'b0; dbg_wr = 1'b0;
      check("wr_c1_bus", {mem_wr, mem_addr, mem_wdata, owner}, {1'b1, 32'h10, 32'h12345678, 1'b1});
      step(1);
      check("wr_c2_busy", busy, 0);
      check("wr_c2_mem", mem[8'h10], 32'h12345678);
      c0 = cyc;
      dbg_req = 1'b1; dbg_addr = 32'h10;
      expect_ev(EV_DBG_GNT, c0 + 1, 32'h10);
      expect_ev(EV_DBG_RV,  c0 + 4, 32'h12345678);
      step(1);
      dbg_req = 1'b0;
      step(4);
      check("cpu_rdata_held", cpu_rdata, 32'hDEADBEEF);

      // Simultaneous reads: CPU first, DBG served after the CPU read completes
      c0 = cyc;
      cpu_req = 1'b1; cpu_addr = 32'h20;
      dbg_req = 1'b1; dbg_addr = 32'h24;
      expect_ev(EV_CPU_GNT, c0 + 1, 32'h20);
      expect_ev(EV_CPU_RV,  c0 + 4, 32'hA5A50001);
      expect_ev(EV_DBG_GNT, c0 + 6, 32'h24);
      expect_ev(EV_DBG_RV,  c0 + 9, 32'h5A5A0002);
      step(1);
      cpu_req = 1'b0;
      step(5);
      dbg_req = 1'b0;
      step(4);
      check("tie_rd_idle", busy, 0);

      // Repeated write ties with both requests held
      c0 = cyc;
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h11110030;
      dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 32'h34; dbg_wdata = 32'h22220034;
      expect_ev(EV_CPU_GNT, c0 + 1, 32'h30);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      expect_ev(EV_DBG_GNT, c0 + 3, 32'h34);
`else
      expect_ev(EV_CPU_GNT, c0 + 3, 32'h30);
`endif
      expect_ev(EV_CPU_GNT, c0 + 5, 32'h30);
      step(5);
      cpu_req = 1'b0; cpu_wr = 1'b0;
      dbg_req = 1'b0; dbg_wr = 1'b0;
      step(1);
      check("tie_wr_idle", busy, 0);
      check("tie_wr_mem30", mem[8'h30], 32'h11110030);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      check("tie_wr_mem34", mem[8'h34], 32'h22220034);
`else
      check("tie_wr_mem34", mem[8'h34], 32'h0);
`endif

      // CPU write arriving while a DBG read is waiting on memory
      c0 = cyc;
      dbg_req = 1'b1; dbg_addr = 32'h24;
      expect_ev(EV_DBG_GNT, c0 + 1, 32'h24);
      expect_ev(EV_DBG_RV,  c0 + 4, 32'h5A5A0002);
      expect_ev(EV_CPU_GNT, c0 + 6, 32'h50);
      step(1);
      dbg_req = 1'b0;
      step(1);
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h50; cpu_wdata = 32'hCAFE0005;
      check("wait_c2_no_wr", mem_wr, 0);
      step(1);
      check("wait_c3_no_wr", mem_wr, 0);
      step(3);
      check("late_wr_c6", {mem_wr, mem_addr, mem_wdata}, {1'b1, 32'h50, 32'hCAFE0005});
      cpu_req = 1'b0; cpu_wr = 1'b0;
      step(1);
      check("late_wr_mem", mem[8'h50], 32'hCAFE0005);

      // Reset during WAIT aborts the read without rvalid
      c0 = cyc;
      cpu_req = 1'b1; cpu_addr = 32'h40;
      expect_ev(EV_CPU_GNT, c0 + 1, 32'h40);
      step(1);
      cpu_req = 1'b0;
      step(1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check("abort_busy_wr", {busy, mem_wr}, 0);
      check("abort_rdata", cpu_rdata, 0);
      c0 = cyc;
      cpu_req = 1'b1; cpu_addr = 32'h20;
      expect_ev(EV_CPU_GNT, c0 + 1, 32'h20);
      expect_ev(EV_CPU_RV,  c0 + 4, 32'hA5A50001);
      step(1);
      cpu_req = 1'b0;
      step(5);
      check("after_abort_idle", busy, 0);

      // RD_LAT=1 instance: rvalid in cycle 3
      c1_cpu_req = 1'b1; c1_cpu_addr = 32'h40;
      step(1);
      c1_cpu_req = 1'b0;
      check("lat1_gnt_c1", c1_cpu_gnt, 1);
      step(1);
      check("lat1_rvalid_c2", c1_cpu_rvalid, 0);
      step(1);
      check("lat1_rvalid_c3", {c1_cpu_rvalid, c1_cpu_rdata}, {1'b1, 32'hDEADBEEF});
      step(1);
      check("lat1_idle_c4", c1_busy, 0);

      step(3);
      check("scoreboard_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
